// File: rtl/control_logic.sv
// Registered main/ALU decoder for the MIPS-subset CPU.
// Turns opcode/funct into the full datapath control vector with one cycle of latency.
module control_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] RegDst,
  output logic       RegWr,
  output logic       ALUSrc,
  output logic [2:0] ALUcntrl,
  output logic       MemWr,
  output logic [1:0] MemToReg,
  output logic       jump,
  output logic       bne,
  output logic       beq
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_XORI  = 6'h0e,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR  = 6'h08,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_SLT = 6'h2a
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_RA  = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

  typedef struct packed {
    reg_dst_e reg_dst;
    logic     reg_wr;
    logic     alu_src;
    alu_op_e  alu_op;
    logic     mem_wr;
    wb_sel_e  mem_to_reg;
    logic     jump;
    logic     bne;
    logic     beq;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Every field starts at its NOP value; each case only raises what it needs,
  // so unlisted opcodes and functs fall through to an all-zero vector.
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            ctrl_d.reg_dst = DST_RD;
            ctrl_d.reg_wr  = 1'b1;
            ctrl_d.alu_op  = ALU_ADD;
          end
          FN_SUB: begin
            ctrl_d.reg_dst = DST_RD;
            ctrl_d.reg_wr  = 1'b1;
            ctrl_d.alu_op  = ALU_SUB;
          end
          FN_SLT: begin
            ctrl_d.reg_dst = DST_RD;
            ctrl_d.reg_wr  = 1'b1;
            ctrl_d.alu_op  = ALU_SLT;
          end
          FN_JR: begin
            ctrl_d.jump = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = WB_MEM;
      end
      OP_SW: begin
        ctrl_d.alu_src = 1'b1;
        ctrl_d.mem_wr  = 1'b1;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.reg_dst    = DST_RA;
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.mem_to_reg = WB_LINK;
        ctrl_d.jump       = 1'b1;
      end
      OP_XORI: begin
        ctrl_d.reg_wr  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_op  = ALU_XOR;
      end
      OP_ADDI: begin
        ctrl_d.reg_wr  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_op  = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.alu_op = ALU_SUB;
        ctrl_d.beq    = 1'b1;
      end
      OP_BNE: begin
        ctrl_d.alu_op = ALU_SUB;
        ctrl_d.bne    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign RegWr    = ctrl_q.reg_wr;
  assign ALUSrc   = ctrl_q.alu_src;
  assign ALUcntrl = ctrl_q.alu_op;
  assign MemWr    = ctrl_q.mem_wr;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign jump     = ctrl_q.jump;
  assign bne      = ctrl_q.bne;
  assign beq      = ctrl_q.beq;

endmodule

// File: tb/tb_control_logic.sv
// Directed bench for control_logic: expected vectors queued at drive time, checked one edge later.
module tb_control_logic;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [1:0] RegDst;
  logic       RegWr;
  logic       ALUSrc;
  logic [2:0] ALUcntrl;
  logic       MemWr;
  logic [1:0] MemToReg;
  logic       jump;
  logic       bne;
  logic       beq;

  int unsigned n_checks;
  int unsigned n_pass;

  typedef struct {
    logic [12:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  // Vector layout: RegDst RegWr ALUSrc ALUcntrl MemWr MemToReg jump bne beq
  localparam logic [12:0] V_NOP  = 13'b00_0_0_000_0_00_0_0_0;
  localparam logic [12:0] V_ADD  = 13'b01_1_0_000_0_00_0_0_0;
  localparam logic [12:0] V_SUB  = 13'b01_1_0_001_0_00_0_0_0;
  localparam logic [12:0] V_SLT  = 13'b01_1_0_011_0_00_0_0_0;
  localparam logic [12:0] V_JR   = 13'b00_0_0_000_0_00_1_0_0;
  localparam logic [12:0] V_LW   = 13'b00_1_1_000_0_01_0_0_0;
  localparam logic [12:0] V_SW   = 13'b00_0_1_000_1_00_0_0_0;
  localparam logic [12:0] V_J    = 13'b00_0_0_000_0_00_1_0_0;
  localparam logic [12:0] V_JAL  = 13'b10_1_0_000_0_10_1_0_0;
  localparam logic [12:0] V_XORI = 13'b00_1_1_010_0_00_0_0_0;
  localparam logic [12:0] V_ADDI = 13'b00_1_1_000_0_00_0_0_0;
  localparam logic [12:0] V_BEQ  = 13'b00_0_0_001_0_00_0_0_1;
  localparam logic [12:0] V_BNE  = 13'b00_0_0_001_0_00_0_1_0;

  control_logic dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .RegDst   (RegDst),
    .RegWr    (RegWr),
    .ALUSrc   (ALUSrc),
    .ALUcntrl (ALUcntrl),
    .MemWr    (MemWr),
    .MemToReg (MemToReg),
    .jump     (jump),
    .bne      (bne),
    .beq      (beq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {RegDst, RegWr, ALUSrc, ALUcntrl, MemWr, MemToReg, jump, bne, beq};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_excl(input string tag);
    logic [12:0] obs;
    obs = observed();
    n_checks++;
    assert (($countones({jump, bne, beq}) <= 1) && !(MemWr && RegWr)) begin
      n_pass++;
    end else begin
      $error("FAIL %s_excl: observed %b expected at most one of jump/bne/beq and not MemWr&RegWr",
             tag, obs);
    end
  endtask

  task automatic pop_and_check();
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, observed(), e.exp);
      check_excl(e.tag);
    end
  endtask

  // Drive inputs on the falling edge, queue the expectation, check just after the next rising edge.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic [12:0] exp);
    sb_entry_t e;
    @(negedge clk);
    opcode = op;
    funct  = fn;
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    opcode   = 6'h23;
    funct    = 6'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", observed(), V_NOP);

    @(negedge clk);
    reset = 1'b1;
    step("lw_after_reset", 6'h23, 6'h00, V_LW);

    step("slt", 6'h00, 6'h2a, V_SLT);
    step("add", 6'h00, 6'h20, V_ADD);
    step("sub", 6'h00, 6'h22, V_SUB);
    step("jr",  6'h00, 6'h08, V_JR);

    step("sw",   6'h2b, 6'h00, V_SW);
    step("xori", 6'h0e, 6'h00, V_XORI);
    step("addi", 6'h08, 6'h00, V_ADDI);
    step("addi_funct_sub", 6'h08, 6'h22, V_ADDI);

    step("j",   6'h02, 6'h00, V_J);
    step("jal", 6'h03, 6'h00, V_JAL);
    step("bne", 6'h05, 6'h00, V_BNE);
    step("beq", 6'h04, 6'h00, V_BEQ);

    step("illegal_op_3f",   6'h3f, 6'h20, V_NOP);
    step("illegal_funct_01", 6'h00, 6'h01, V_NOP);
    step("lw_after_nop", 6'h23, 6'h2a, V_LW);

    // Inputs changed right after an edge must not reach the outputs before the next edge.
    step("addi_before_hold", 6'h08, 6'h00, V_ADDI);
    opcode = 6'h2b;
    @(negedge clk);
    check("hold_addi_midcycle", observed(), V_ADDI);
    begin
      sb_entry_t e;
      e.exp = V_SW;
      e.tag = "sw_after_hold";
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pop_and_check();

    // Reset pulse between edges clears outputs asynchronously.
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clear", observed(), V_NOP);
    #1;
    reset = 1'b1;
    #0;
    check("cleared_after_release", observed(), V_NOP);
    step("beq_after_pulse", 6'h04, 6'h3f, V_BEQ);

    n_checks++;
    assert (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
